div: RTL

Iterative 32-bit integer divider for the execute stage, the sequential counterpart of the combinational Booth/Wallace multiplier `mul`. It serves DIV.W/MOD.W/DIV.WU/MOD.WU with a valid/ready start handshake and a one-cycle `complete` pulse. It computes quotient and remainder in one pass using a radix-2 restoring algorithm on operand magnitudes, followed by sign correction. Latency is fixed; there is no early termination.

---
 rtl/div_pkg.sv | 22 ++
 rtl/div_step.sv | 24 ++
 rtl/div.sv | 116 +++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative radix-2 restoring divider.
package div_pkg;

  localparam int DIV_W     = 32;
  localparam int DIV_CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } div_state_t;

  function automatic logic [DIV_W-1:0] negOf(input logic [DIV_W-1:0] v);
    return ~v + DIV_W'(1);
  endfunction

  // Magnitude of an operand; unsigned or non-negative values pass through untouched.
  function automatic logic [DIV_W-1:0] magOf(input logic [DIV_W-1:0] v, input logic isSigned);
    return (isSigned && v[DIV_W-1]) ? negOf(v) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: trial subtract, keep or restore.
module div_step
  import div_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic [W-1:0] rem,
  input  logic         dvdBit,
  input  logic [W-1:0] yMag,
  output logic [W-1:0] remNext,
  output logic         quoBit
);

  logic [W:0] trial;

  // The shifted remainder is always below 2*yMag, so bit W of the
  // 33-bit trial is a reliable sign bit.
  always_comb begin
    trial   = {rem, dvdBit} - {1'b0, yMag};
    quoBit  = ~trial[W];
    remNext = quoBit ? trial[W-1:0] : {rem[W-2:0], dvdBit};
  end

endmodule

// File: rtl/div.sv
// Iterative 32-bit signed/unsigned divider: 32 restoring steps on magnitudes,
// then sign correction; valid/ready start, one-cycle complete pulse.
module div #(
  parameter int DIV_W = 32
) (
  input  logic             div_clk,
  input  logic             reset,
  input  logic             div_valid,
  output logic             div_ready,
  input  logic             div_signed,
  input  logic [DIV_W-1:0] x,
  input  logic [DIV_W-1:0] y,
  input  logic             div_cancel,
  output logic             complete,
  output logic [DIV_W-1:0] s,
  output logic [DIV_W-1:0] r
);

  import div_pkg::*;

  div_state_t           state;
  div_state_t           stateNext;
  logic [DIV_CNT_W-1:0] cnt;
  logic [DIV_W-1:0]     remReg;
  logic [DIV_W-1:0]     dvdReg;
  logic [DIV_W-2:0]     quoReg;
  logic [DIV_W-1:0]     yMag;
  logic                 qNeg;
  logic                 rNeg;
  logic                 yZero;
  logic                 readyReg;
  logic                 completeReg;
  logic                 accept;
  logic [DIV_W-1:0]     remNext;
  logic                 quoBit;
  logic [DIV_W-1:0]     quoFinal;

  assign accept    = div_valid & readyReg & ~div_cancel;
  assign quoFinal  = {quoReg, quoBit};
  assign div_ready = readyReg;
  assign complete  = completeReg;

  div_step #(.W(DIV_W)) u_step (
    .rem    (remReg),
    .dvdBit (dvdReg[DIV_W-1]),
    .yMag   (yMag),
    .remNext(remNext),
    .quoBit (quoBit)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge div_clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  // NOTE: default assigned first so no path through this block leaves
  // stateNext unassigned, which would infer a latch.
  always_comb begin
    stateNext = state;
    if (div_cancel) begin
      stateNext = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (accept) stateNext = CALC;
        CALC:    if (cnt == '0) stateNext = DONE;
        DONE:    stateNext = accept ? CALC : IDLE;
        default: stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge div_clk or negedge reset) begin
    if (!reset) begin
      cnt         <= '0;
      remReg      <= '0;
      dvdReg      <= '0;
      quoReg      <= '0;
      yMag        <= '0;
      qNeg        <= 1'b0;
      rNeg        <= 1'b0;
      yZero       <= 1'b0;
      readyReg    <= 1'b1;
      completeReg <= 1'b0;
      s           <= '0;
      r           <= '0;
    end else begin
      completeReg <= 1'b0;
      readyReg    <= (stateNext != CALC);
      if (accept) begin
        dvdReg <= magOf(x, div_signed);
        yMag   <= magOf(y, div_signed);
        qNeg   <= div_signed & (x[DIV_W-1] ^ y[DIV_W-1]);
        rNeg   <= div_signed & x[DIV_W-1];
        yZero  <= (y == '0);
        remReg <= '0;
        quoReg <= '0;
        cnt    <= DIV_CNT_W'(DIV_W - 1);
      end else if (state == CALC && !div_cancel) begin
        remReg <= remNext;
        dvdReg <= {dvdReg[DIV_W-2:0], 1'b0};
        quoReg <= quoFinal[DIV_W-2:0];
        cnt    <= cnt - DIV_CNT_W'(1);
        if (cnt == '0) begin
          // With y=0 the remainder ends as |x|, so correcting it restores x;
          // only the all-ones quotient must escape negation.
          s           <= (qNeg && !yZero) ? negOf(quoFinal) : quoFinal;
          r           <= rNeg ? negOf(remNext) : remNext;
          completeReg <= 1'b1;
        end
      end
    end
  end

endmodule
